// File: rtl/traffic_phase_arbiter.sv
// traffic_phase_arbiter
//
// Actuated phase scheduler for a four-phase intersection
// (0 NS_CROSS, 1 NS_ROAD, 2 EW_CROSS, 3 EW_ROAD).
//
// Demand from detectors and push-buttons is latched into a pending register.
// Phases are served round-robin, starting the search one past the phase that
// was served last. Each served phase goes GREEN, then YELLOW, then ALL_RED.
// GREEN lasts at least MIN_GREEN cycles and at most MAX_GREEN cycles, but only
// while another phase is waiting. YELLOW always lasts YELLOW_TIME cycles.
// ALL_RED lasts at least ALL_RED_TIME cycles.
//
// Optional feature (build macro PREEMPT_EN): emergency preemption. When it is
// enabled, a preempt request ends the current green through a full yellow and
// all-red. The arbiter then serves preempt_phase_i and holds that phase green
// for as long as preempt_i stays high. Without the macro, preempt_i and
// preempt_phase_i are ignored and preempt_active_o is tied low.
//
// Ports:
//   clk               clock, all state changes on the rising edge
//   reset_n           synchronous active-low reset
//   req_i[3:0]        per-phase demand, either a level or a one-cycle pulse
//   preempt_i         emergency preempt request (PREEMPT_EN builds only)
//   preempt_phase_i   phase to serve under preempt
//   lamp_o[11:0]      lamp of phase p at [3p+2:3p]; RED=100 YELLOW=010 GREEN=001
//   grant_o[3:0]      one-hot, set while the served phase is GREEN or YELLOW
//   phase_o[1:0]      phase currently or most recently served
//   preempt_active_o  high while a preempt sequence is in progress
//
// lamp_o and grant_o are decoded combinationally from the registered state and
// phase, so they add no pipeline delay.
module traffic_phase_arbiter #(
  parameter int MIN_GREEN    = 10,
  parameter int MAX_GREEN    = 40,
  parameter int YELLOW_TIME  = 5,
  parameter int ALL_RED_TIME = 2,
  parameter int TIMER_W      = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req_i,
  input  logic        preempt_i,
  input  logic [1:0]  preempt_phase_i,
  output logic [11:0] lamp_o,
  output logic [3:0]  grant_o,
  output logic [1:0]  phase_o,
  output logic        preempt_active_o
);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_t;

  // A state is finished once the timer reaches (duration - 1). The timer
  // counts from 0 on the first cycle of each state.
  localparam logic [TIMER_W-1:0] MIN_LAST = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAX_LAST = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YEL_LAST = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] AR_LAST  = TIMER_W'(ALL_RED_TIME - 1);

  state_t             state;
  state_t             nxt_state;
  logic [TIMER_W-1:0] timer;
  logic [3:0]         pend;
  logic [1:0]         phase;
  logic [1:0]         nxt_phase;
  logic [3:0]         dem;
  logic [3:0]         other;
  logic [3:0]         enter_mask;
  logic [1:0]         pick;
  logic               timer_clr;
  logic               pre_seq;
  logic               pre_hold;
  logic               pre_cut;
  logic [1:0]         pre_tgt;

`ifdef PREEMPT_EN
  logic               preempt_active;
  logic [1:0]         preempt_tgt;
`else
  logic               unused_preempt;
  assign unused_preempt = &{1'b0, preempt_i, preempt_phase_i};
`endif

  // Rotating priority: the search starts at last+1 and wraps around. The loop
  // runs from the lowest priority (last itself) to the highest (last+1), so the
  // last hit it records is the highest-priority phase with demand.
  function automatic logic [1:0] rr_pick(input logic [3:0] d, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (d[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    dem   = pend | req_i;
    other = dem & ~(4'b0001 << phase);
    pick  = rr_pick(dem, phase);

`ifdef PREEMPT_EN
    // The preempt target is sampled live while preempt_i is high. After
    // preempt_i drops, the last sampled target still finishes the sequence.
    pre_tgt  = preempt_i ? preempt_phase_i : preempt_tgt;
    pre_seq  = preempt_i | preempt_active;
    pre_hold = preempt_i & (phase == preempt_phase_i);
    pre_cut  = preempt_i & (phase != preempt_phase_i);
`else
    pre_tgt  = pick;
    pre_seq  = 1'b0;
    pre_hold = 1'b0;
    pre_cut  = 1'b0;
`endif

    nxt_state = state;
    nxt_phase = phase;
    timer_clr = 1'b0;

    case (state)
      ST_ALL_RED: begin
        if (timer >= AR_LAST) begin
          if (pre_seq) begin
            nxt_state = ST_GREEN;
            nxt_phase = pre_tgt;
          end else if (|dem) begin
            nxt_state = ST_GREEN;
            nxt_phase = pick;
          end
        end
      end
      ST_GREEN: begin
        if (pre_hold) begin
          // The timer is held at 0 while the preempt hold lasts, so normal
          // timing starts again from 0 once preempt_i drops.
          timer_clr = 1'b1;
        end else if (pre_cut) begin
          nxt_state = ST_YELLOW;
        end else if ((|other) && ((!req_i[phase] && (timer >= MIN_LAST)) ||
                                  (timer >= MAX_LAST))) begin
          nxt_state = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (timer >= YEL_LAST) nxt_state = ST_ALL_RED;
      end
      default: nxt_state = ST_ALL_RED;
    endcase

    // Entering GREEN serves the pending request of that phase. A request that
    // is still high on that same edge stays pending.
    if ((state != ST_GREEN) && (nxt_state == ST_GREEN)) enter_mask = 4'b0001 << nxt_phase;
    else                                                enter_mask = 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_ALL_RED;
      timer <= '0;
      pend  <= 4'b0000;
      phase <= 2'd3;
`ifdef PREEMPT_EN
      preempt_active <= 1'b0;
      preempt_tgt    <= 2'd0;
`endif
    end else begin
      state <= nxt_state;
      phase <= nxt_phase;
      pend  <= dem & ~(enter_mask & ~req_i);
      if ((nxt_state != state) || timer_clr) timer <= '0;
      else if (!(&timer))                    timer <= timer + 1'b1;
`ifdef PREEMPT_EN
      if (preempt_i) begin
        preempt_active <= 1'b1;
        preempt_tgt    <= preempt_phase_i;
      end else if (preempt_active && (state == ST_GREEN) && (phase == preempt_tgt)) begin
        preempt_active <= 1'b0;
      end
`endif
    end
  end

  always_comb begin
    lamp_o  = {4{3'b100}};
    grant_o = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      if ((state != ST_ALL_RED) && (phase == 2'(p))) begin
        lamp_o[3*p +: 3] = (state == ST_GREEN) ? 3'b001 : 3'b010;
        grant_o[p]       = 1'b1;
      end
    end
  end

  assign phase_o = phase;

`ifdef PREEMPT_EN
  assign preempt_active_o = preempt_active;
`else
  assign preempt_active_o = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Bench for traffic_phase_arbiter.
//
// A cycle model derived from the phase rules runs beside the DUT, and its
// outputs are compared on every falling edge. Directed sequences also check
// lamp values that were worked out by hand for the test scenarios.
`timescale 1ns/1ps
module tb_traffic_phase_arbiter;

  localparam int MIN_G = 4;
  localparam int MAX_G = 8;
  localparam int YEL_T = 2;
  localparam int AR_T  = 1;

  localparam int C_RED = 0;
  localparam int C_GRN = 1;
  localparam int C_YEL = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_i = 4'b0000;
  logic        preempt_i = 1'b0;
  logic [1:0]  preempt_phase_i = 2'd0;
  logic [11:0] lamp_o;
  logic [3:0]  grant_o;
  logic [1:0]  phase_o;
  logic        preempt_active_o;

  logic [3:0]  held = 4'b0000;
  int          n_vec = 0;
  int          n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  traffic_phase_arbiter #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_TIME(YEL_T),
    .ALL_RED_TIME(AR_T), .TIMER_W(7)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_i(req_i),
    .preempt_i(preempt_i), .preempt_phase_i(preempt_phase_i),
    .lamp_o(lamp_o), .grant_o(grant_o), .phase_o(phase_o),
    .preempt_active_o(preempt_active_o)
  );

  // ---------------- helpers ----------------
  function automatic logic [11:0] lamp_of(input int ph, input int color);
    logic [11:0] l;
    l = {4{3'b100}};
    if (color == C_GRN) l[3*ph +: 3] = 3'b001;
    if (color == C_YEL) l[3*ph +: 3] = 3'b010;
    return l;
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_color = C_RED;
  int       m_phase = 3;
  int       m_age = 0;
  bit [3:0] m_pend = 4'b0000;
  bit       m_pact = 1'b0;
  int       m_ptgt = 0;
  bit       model_valid = 1'b0;

  task automatic model_step();
    bit [3:0] req;
    bit [3:0] dem;
    bit [3:0] oth;
    bit       pre;
    int       pph;
    int       tgt;
    int       nc;
    int       np;
    bit       hold;
    req = req_i;
    pre = 1'b0;
    pph = 0;
`ifdef PREEMPT_EN
    pre = preempt_i;
    pph = int'(preempt_phase_i);
`endif
    if (!reset_n) begin
      m_color = C_RED; m_phase = 3; m_age = 0; m_pend = 4'b0000; m_pact = 1'b0; m_ptgt = 0;
      return;
    end
    dem  = m_pend | req;
    nc   = m_color;
    np   = m_phase;
    hold = 1'b0;
    tgt  = pre ? pph : m_ptgt;
    if (m_color == C_RED) begin
      if (m_age + 1 >= AR_T) begin
        if (pre || m_pact) begin
          nc = C_GRN; np = tgt;
        end else begin
          for (int k = 1; k <= 4; k++) begin
            if (dem[(m_phase + k) % 4]) begin
              nc = C_GRN; np = (m_phase + k) % 4;
              break;
            end
          end
        end
      end
    end else if (m_color == C_GRN) begin
      oth = dem;
      oth[m_phase] = 1'b0;
      if (pre && (m_phase == pph)) hold = 1'b1;
      else if (pre) nc = C_YEL;
      else if ((oth != 0) && ((!req[m_phase] && (m_age + 1 >= MIN_G)) || (m_age + 1 >= MAX_G)))
        nc = C_YEL;
    end else begin
      if (m_age + 1 >= YEL_T) nc = C_RED;
    end
    if (pre) m_pact = 1'b1;
    else if (m_pact && (m_color == C_GRN) && (m_phase == tgt)) m_pact = 1'b0;
    if (pre) m_ptgt = pph;
    m_pend = dem;
    if ((nc == C_GRN) && (m_color != C_GRN) && !req[np]) m_pend[np] = 1'b0;
    m_age   = ((nc != m_color) || hold) ? 0 : m_age + 1;
    m_color = nc;
    m_phase = np;
  endtask

  always @(posedge clk) begin
    model_step();
    model_valid = 1'b1;
  end

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk) begin
    logic [3:0] g;
    if (model_valid) begin
      g = (m_color == C_RED) ? 4'b0000 : (4'b0001 << m_phase);
      chk("model_lamp", lamp_o, lamp_of(m_phase, m_color));
      chk("model_grant", {8'b0, grant_o}, {8'b0, g});
      chk("model_phase", {10'b0, phase_o}, 12'(m_phase));
      chk("model_preempt", {11'b0, preempt_active_o}, {11'b0, m_pact});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    reset_n   = 1'b0;
    held      = 4'b0000;
    req_i     = 4'b0000;
    preempt_i = 1'b0;
    repeat (n) @(negedge clk);
    chk("reset_lamp", lamp_o, 12'b100_100_100_100);
    chk("reset_grant", {8'b0, grant_o}, 12'd0);
    chk("reset_phase", {10'b0, phase_o}, 12'd3);
    chk("reset_preempt", {11'b0, preempt_active_o}, 12'd0);
  endtask

  // Called on the falling edge where the first green cycle is visible.
  // `pulse` is ORed onto req_i for one cycle at green index pulse_idx.
  task automatic expect_seq(input int ph, input int g, input int y, input int a,
                            input logic [3:0] pulse, input int pulse_idx);
    logic [3:0] gm;
    gm = 4'b0001 << ph;
    for (int i = 0; i < g; i++) begin
      chk("seq_green", lamp_o, lamp_of(ph, C_GRN));
      chk("seq_green_grant", {8'b0, grant_o}, {8'b0, gm});
      if (i == pulse_idx) req_i = held | pulse;
      @(negedge clk);
      req_i = held;
    end
    for (int i = 0; i < y; i++) begin
      chk("seq_yellow", lamp_o, lamp_of(ph, C_YEL));
      chk("seq_yellow_grant", {8'b0, grant_o}, {8'b0, gm});
      @(negedge clk);
    end
    for (int i = 0; i < a; i++) begin
      chk("seq_all_red", lamp_o, 12'b100_100_100_100);
      chk("seq_all_red_grant", {8'b0, grant_o}, 12'd0);
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1: reset for two cycles, then a one-cycle request for phase 0
    do_reset(2);
    reset_n = 1'b1;
    req_i   = 4'b0001;
    @(negedge clk);
    req_i = held;
    chk("t1_lamp0", {9'b0, lamp_o[2:0]}, 12'b001);
    chk("t1_grant", {8'b0, grant_o}, 12'b0001);
    chk("t1_phase", {10'b0, phase_o}, 12'd0);

    // 2: gap-out after MIN_GREEN; the phase 2 pulse is served next
    expect_seq(0, 4, 2, 1, 4'b0100, 0);
    chk("t2_lamp2", {9'b0, lamp_o[8:6]}, 12'b001);
    chk("t2_phase", {10'b0, phase_o}, 12'd2);

    // 3: phase 0 request held; max-out after MAX_GREEN, then phase 1.
    // This reset is taken while phase 2 is still green.
    do_reset(1);
    reset_n = 1'b1;
    held    = 4'b0001;
    req_i   = held;
    @(negedge clk);
    expect_seq(0, 8, 2, 1, 4'b0010, 0);
    chk("t3_lamp", lamp_o, 12'b100_100_001_100);
    chk("t3_phase", {10'b0, phase_o}, 12'd1);

    // 4: all four phases held; round-robin 0,1,2,3 then back to 0
    do_reset(1);
    reset_n = 1'b1;
    held    = 4'b1111;
    req_i   = held;
    @(negedge clk);
    for (int ph = 0; ph < 4; ph++) expect_seq(ph, 8, 2, 1, 4'b0000, -1);
    chk("t4_wrap_lamp", lamp_o, 12'b100_100_100_001);
    chk("t4_wrap_phase", {10'b0, phase_o}, 12'd0);

    // 5: lone phase 1 rests in green. A phase 2 pulse on green cycle 129
    // must gap out at once, which only works if the timer saturated.
    do_reset(1);
    reset_n = 1'b1;
    req_i   = 4'b0010;
    @(negedge clk);
    req_i = held;
    expect_seq(1, 129, 2, 1, 4'b0100, 128);
    chk("t5_next_lamp", lamp_o, 12'b100_001_100_100);
    chk("t5_next_phase", {10'b0, phase_o}, 12'd2);

    // 6: preempt to phase 3 during phase 0 green
    do_reset(1);
    reset_n = 1'b1;
    held    = 4'b0001;
    req_i   = held;
    @(negedge clk);
    chk("t6_green0", lamp_o, 12'b100_100_100_001);
    preempt_i       = 1'b1;
    preempt_phase_i = 2'd3;
    held            = 4'b0111;
    req_i           = held;
    @(negedge clk);
`ifdef PREEMPT_EN
    for (int i = 0; i < 2; i++) begin
      chk("t6_yellow", lamp_o, 12'b100_100_100_010);
      chk("t6_active_y", {11'b0, preempt_active_o}, 12'd1);
      @(negedge clk);
    end
    chk("t6_all_red", lamp_o, 12'b100_100_100_100);
    chk("t6_active_r", {11'b0, preempt_active_o}, 12'd1);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk("t6_hold_lamp", lamp_o, 12'b001_100_100_100);
      chk("t6_hold_phase", {10'b0, phase_o}, 12'd3);
      chk("t6_active_g", {11'b0, preempt_active_o}, 12'd1);
      @(negedge clk);
    end
    preempt_i = 1'b0;
    repeat (12) @(negedge clk);
`else
    // Preempt is ignored: phase 0 keeps green until max-out, then phase 1
    chk("t6_no_preempt", {11'b0, preempt_active_o}, 12'd0);
    expect_seq(0, 7, 2, 1, 4'b0000, -1);
    chk("t6_next_lamp", lamp_o, 12'b100_100_001_100);
    preempt_i = 1'b0;
    repeat (4) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
